// File: rtl/fir_pkg.sv
// Shared sizing, FSM state type and the Q15 round/saturate helper for the FIR MAC sequencer.
package fir_pkg;

  localparam int TAPS      = 32;
  localparam int ADDR_W    = $clog2(TAPS);
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int PROD_W    = DATA_W + COEF_W;
  localparam int ACC_W     = PROD_W + ADDR_W;
  localparam int DRAIN_CYC = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    MAC,
    DRAIN,
    ROUND,
    OUT
  } state_t;

  // Round half up at the Q15 point, then clamp into the signed DATA_W range.
  function automatic logic signed [DATA_W-1:0] round_sat_q15(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] half_lsb;
    logic signed [ACC_W-1:0] sat_max;
    logic signed [ACC_W-1:0] sat_min;
    logic signed [ACC_W-1:0] rounded;
    half_lsb = $signed(ACC_W'(1 << (COEF_W - 2)));
    sat_max  = ACC_W'((1 << (DATA_W - 1)) - 1);
    sat_min  = ACC_W'(-(1 << (DATA_W - 1)));
    rounded  = (acc + half_lsb) >>> (COEF_W - 1);
    if (rounded > sat_max) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (rounded < sat_min) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end
    return DATA_W'(rounded);
  endfunction

endpackage

// File: rtl/fir_mac_seq_if.sv
// Bundle of the sample/result handshakes and the shift-register / coefficient ROM pins.
interface fir_mac_seq_if;
  import fir_pkg::*;

  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              clear;
  logic [DATA_W-1:0] shift_probka;
  logic              shift_new;
  logic              shift_clear;
  logic [ADDR_W-1:0] shift_adres;
  logic [DATA_W-1:0] shift_data;
  logic [ADDR_W-1:0] coef_adres;
  logic [COEF_W-1:0] coef_data;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              result_ready;
  logic              busy;

  modport master (
    input  sample_in, sample_valid, clear, shift_data, coef_data, result_ready,
    output sample_ready, shift_probka, shift_new, shift_clear, shift_adres,
           coef_adres, result, result_valid, busy
  );

  modport slave (
    output sample_in, sample_valid, clear, shift_data, coef_data, result_ready,
    input  sample_ready, shift_probka, shift_new, shift_clear, shift_adres,
           coef_adres, result, result_valid, busy
  );

endinterface

// File: rtl/fir_mac_dp.sv
// MAC datapath: sample/product/accumulate pipeline with a travelling valid bit, plus the output rounding register.
module fir_mac_dp
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_clr,
  input  logic              tap_vld,
  input  logic              round_en,
  input  logic [DATA_W-1:0] shift_data,
  input  logic [COEF_W-1:0] coef_data,
  output logic [DATA_W-1:0] result
);

  localparam int VLD_D = 2;

  logic signed [DATA_W-1:0] samp_d_reg;
  logic signed [PROD_W-1:0] prod_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [DATA_W-1:0]        result_reg;
  logic [VLD_D-1:0]         vld_reg;
  logic [VLD_D-1:0]         vld_next;

  // vld_reg[0] qualifies samp_d, vld_reg[1] qualifies prod.
  generate
    for (genvar gi = 0; gi < VLD_D; gi++) begin : g_vld
      if (gi == 0) begin : g_head
        assign vld_next[gi] = tap_vld;
      end else begin : g_tail
        assign vld_next[gi] = vld_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_d_reg <= '0;
      prod_reg   <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      vld_reg    <= '0;
    end else begin
      vld_reg    <= vld_next;
      samp_d_reg <= shift_data;
      // coef_data arrives one cycle after its address, aligned with samp_d.
      prod_reg   <= samp_d_reg * $signed(coef_data);
      if (acc_clr) begin
        acc_reg <= '0;
      end else if (vld_reg[VLD_D-1]) begin
        acc_reg <= acc_reg + ACC_W'(prod_reg);
      end
      if (round_en) begin
        result_reg <= round_sat_q15(acc_reg);
      end
    end
  end

  assign result = result_reg;

endmodule

// File: rtl/fir_mac_seq.sv
// FIR read-side sequencer: accepts a sample, pushes it into the shift register, sweeps all taps and hands out one Q15 result.
module fir_mac_seq
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fir_mac_seq_if.master bus
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              clear_pend_reg, clear_pend_next;
  logic [DATA_W-1:0] probka_reg, probka_next;

  logic              sample_ready;
  logic              shift_new;
  logic              shift_clear;
  logic              result_valid;
  logic              acc_clr;
  logic              tap_vld;
  logic              round_en;
  logic [ADDR_W-1:0] tap_adres;
  logic [DATA_W-1:0] result_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      clear_pend_reg <= 1'b0;
      probka_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      clear_pend_reg <= clear_pend_next;
      probka_reg     <= probka_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    clear_pend_next = clear_pend_reg;
    probka_next     = probka_reg;
    sample_ready    = 1'b0;
    shift_new       = 1'b0;
    shift_clear     = 1'b0;
    result_valid    = 1'b0;
    acc_clr         = 1'b0;
    tap_vld         = 1'b0;
    round_en        = 1'b0;
    tap_adres       = '0;

    // A clear that arrives mid-computation is parked until the block is idle again.
    if (state_reg != IDLE && bus.clear) begin
      clear_pend_next = 1'b1;
    end

    unique case (state_reg)
      IDLE: begin
        if (bus.clear || clear_pend_reg) begin
          shift_clear     = 1'b1;
          clear_pend_next = 1'b0;
        end else begin
          sample_ready = 1'b1;
          if (bus.sample_valid) begin
            probka_next = bus.sample_in;
            state_next  = SHIFT;
          end
        end
      end
      SHIFT: begin
        shift_new  = 1'b1;
        acc_clr    = 1'b1;
        cnt_next   = '0;
        state_next = MAC;
      end
      MAC: begin
        tap_adres = cnt_reg;
        tap_vld   = 1'b1;
        if (cnt_reg == ADDR_W'(TAPS - 1)) begin
          cnt_next   = '0;
          state_next = DRAIN;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_reg == ADDR_W'(DRAIN_CYC - 1)) begin
          cnt_next   = '0;
          state_next = ROUND;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end
      ROUND: begin
        round_en   = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        result_valid = 1'b1;
        if (bus.result_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  fir_mac_dp u_dp (
    .clk        (clk),
    .rst        (rst),
    .acc_clr    (acc_clr),
    .tap_vld    (tap_vld),
    .round_en   (round_en),
    .shift_data (bus.shift_data),
    .coef_data  (bus.coef_data),
    .result     (result_w)
  );

  assign bus.sample_ready = sample_ready;
  assign bus.shift_probka = probka_reg;
  assign bus.shift_new    = shift_new;
  assign bus.shift_clear  = shift_clear;
  assign bus.shift_adres  = tap_adres;
  assign bus.coef_adres   = tap_adres;
  assign bus.result       = result_w;
  assign bus.result_valid = result_valid;
  assign bus.busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_fir_mac_seq.sv
// Scoreboard bench for fir_mac_seq with a shift-register model and a synchronous coefficient ROM.
module tb_fir_mac_seq;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst;

  fir_mac_seq_if bus ();

  fir_mac_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] sr [TAPS];
  logic [COEF_W-1:0] coef_rom [TAPS];

  always @(posedge clk) begin
    if (bus.shift_clear) begin
      for (int i = 0; i < TAPS; i++) sr[i] <= '0;
    end else if (bus.shift_new) begin
      for (int i = TAPS - 1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= bus.shift_probka;
    end
  end

  assign bus.shift_data = sr[bus.shift_adres];

  always @(posedge clk) bus.coef_data <= coef_rom[bus.coef_adres];

  logic [DATA_W-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;
  int n_res = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction

  function automatic void timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout required event", name);
  endfunction

  // Monitor: one pop per accepted result.
  always @(negedge clk) begin
    if (!rst && bus.result_valid && bus.result_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL result_unexpected: got %h required none", bus.result);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        n_res++;
        $display("result %0d: got %h expect %h", n_res, bus.result, e);
        check("result", bus.result, e);
      end
    end
  end

  task automatic set_coefs(input logic [COEF_W-1:0] fill, input int k, input logic [COEF_W-1:0] val);
    for (int i = 0; i < TAPS; i++) coef_rom[i] = fill;
    if (k >= 0) coef_rom[k] = val;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    #1;
    check("clr_strobe", bus.shift_clear, 1);
    check("clr_ready", bus.sample_ready, 0);
    @(negedge clk);
    bus.clear = 1'b0;
    #1;
    check("clr_done", bus.shift_clear, 0);
  endtask

  // Returns 1 ns after the accepting edge E0.
  task automatic send(input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] e);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.sample_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timeout("send_ready");
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    exp_q.push_back(e);
    $display("send %h expect %h", s, e);
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timeout("wait_done");
  endtask

  initial begin
    int n;
    logic sn_seen;
    logic sc_seen;
    rst              = 1'b1;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.clear        = 1'b0;
    bus.result_ready = 1'b1;
    set_coefs('0, 0, 16'h4000);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_sample_ready", bus.sample_ready, 1);
    check("rst_shift_new", bus.shift_new, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_adres", bus.shift_adres, 0);
    @(negedge clk);
    rst = 1'b0;

    // Impulse response and pipeline timing
    do_clear();
    send(16'h1000, 16'h0800);
    check("e0_shift_new", bus.shift_new, 1);
    check("e0_ready", bus.sample_ready, 0);
    check("e0_busy", bus.busy, 1);
    sn_seen = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk);
      #1;
      sn_seen |= bus.shift_new;
      if (c == 1) begin
        check("e1_adres", bus.shift_adres, 0);
        check("e1_coef_adres", bus.coef_adres, 0);
      end
      if (c == 2) check("e2_adres", bus.shift_adres, 1);
      if (c == 32) check("e32_adres", bus.shift_adres, 31);
      if (c == 33) check("e33_adres", bus.shift_adres, 0);
      if (c == 35) check("e35_rvalid", bus.result_valid, 0);
      if (c == 36) begin
        check("e36_rvalid", bus.result_valid, 1);
        check("e36_result", bus.result, 16'h0800);
      end
    end
    check("shift_new_once", sn_seen, 0);
    wait_done();

    // Tap alignment: only tap 3 set; 32767*256 rounds up to 0x0100
    do_clear();
    set_coefs('0, 3, 16'h7FFF);
    send(16'h0100, 16'h0000);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h0100);
    wait_done();

    // Saturation, positive then negative full scale
    do_clear();
    set_coefs(16'h7FFF, -1, '0);
    for (int i = 0; i < TAPS; i++) send(16'h7FFF, (i == 0) ? 16'h7FFE : 16'h7FFF);
    wait_done();
    do_clear();
    for (int i = 0; i < TAPS; i++) send(16'h8000, (i == 0) ? 16'h8001 : 16'h8000);
    wait_done();

    // Back-pressure
    set_coefs('0, 0, 16'h4000);
    bus.result_ready = 1'b0;
    send(16'h0600, 16'h0300);
    n = 0;
    while (!bus.result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("bp_rvalid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_result", bus.result, 16'h0300);
      check("bp_rvalid", bus.result_valid, 1);
      check("bp_ready", bus.sample_ready, 0);
      check("bp_shift_new", bus.shift_new, 0);
    end
    bus.result_ready = 1'b1;
    wait_done();
    check("result_hold", bus.result, 16'h0300);

    // Clear during MAC is deferred to the first idle cycle
    send(16'h2000, 16'h1000);
    repeat (5) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    sc_seen = 1'b0;
    n = 0;
    while (!bus.result_valid && n < 100) begin
      sc_seen |= bus.shift_clear;
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("clr_rvalid");
    check("clr_deferred", sc_seen, 0);
    bus.sample_in    = 16'h0A00;
    bus.sample_valid = 1'b1;
    exp_q.push_back(16'h0500);
    @(negedge clk);
    check("clr_idle_strobe", bus.shift_clear, 1);
    check("clr_idle_ready", bus.sample_ready, 0);
    check("clr_idle_busy", bus.busy, 0);
    @(negedge clk);
    check("clr_after_strobe", bus.shift_clear, 0);
    check("clr_after_ready", bus.sample_ready, 1);
    check("clr_after_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    check("clr_accept", bus.shift_new, 1);
    bus.sample_valid = 1'b0;
    wait_done();

    // Clear together with sample_valid in IDLE
    @(negedge clk);
    bus.clear        = 1'b1;
    bus.sample_in    = 16'h0400;
    bus.sample_valid = 1'b1;
    exp_q.push_back(16'h0200);
    #1;
    check("clrv_ready", bus.sample_ready, 0);
    check("clrv_strobe", bus.shift_clear, 1);
    @(posedge clk);
    #1;
    check("clrv_no_accept", bus.shift_new, 0);
    check("clrv_busy", bus.busy, 0);
    @(negedge clk);
    bus.clear = 1'b0;
    #1;
    check("clrv_ready2", bus.sample_ready, 1);
    @(posedge clk);
    #1;
    check("clrv_accept", bus.shift_new, 1);
    bus.sample_valid = 1'b0;
    wait_done();

    // Asynchronous reset in the middle of the tap sweep
    send(16'h1234, 16'h0000);
    n = 0;
    while (bus.shift_adres != 5'd15 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) timeout("rst_adres15");
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", bus.sample_ready, 1);
    check("arst_shift_new", bus.shift_new, 0);
    check("arst_shift_clear", bus.shift_clear, 0);
    check("arst_probka", bus.shift_probka, 0);
    check("arst_adres", bus.shift_adres, 0);
    check("arst_coef_adres", bus.coef_adres, 0);
    check("arst_result", bus.result, 0);
    check("arst_rvalid", bus.result_valid, 0);
    check("arst_busy", bus.busy, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    send(16'h0800, 16'h0400);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
